// File: rtl/score_bcd_counter_if.sv
// Control/display bundle between the game logic and the score keeper.
// Master drives the game event pulses and the display select; slave returns the display state.
interface score_bcd_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    game_start;
  logic                    point;
  logic                    game_over;
  logic                    show_high;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    score_max;
  logic                    new_high;
  logic                    blank;

  modport master (
    output game_start, point, game_over, show_high,
    input  digits, score_max, new_high, blank
  );

  modport slave (
    input  game_start, point, game_over, show_high,
    output digits, score_max, new_high, blank
  );
endinterface

// File: rtl/score_bcd_counter.sv
// Block-dodger score keeper: saturating BCD score, session high score,
// registered digit display and new-high-score blink control.
module score_bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  score_bcd_counter_if.slave bus
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [W-1:0] ALL9 = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state_q;
  logic [W-1:0]  score_q, high_q, digits_q;
  logic [W-1:0]  score_d;
  logic          score_max_q, new_high_q, blank_q, over_first_q;
  logic [CW-1:0] blink_cnt_q;

  // Single-cycle ripple increment; a 9 wraps to 0 and carries on.
  always_comb begin
    logic       carry;
    logic [3:0] nib;
    score_d = score_q;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = score_q[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          score_d[4*i +: 4] = 4'd0;
        end else begin
          score_d[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      score_q      <= '0;
      high_q       <= '0;
      digits_q     <= '0;
      score_max_q  <= 1'b0;
      new_high_q   <= 1'b0;
      blank_q      <= 1'b0;
      over_first_q <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      digits_q <= bus.show_high ? high_q : score_q;
      if (bus.game_start) begin
        state_q      <= RUN;
        score_q      <= '0;
        score_max_q  <= 1'b0;
        new_high_q   <= 1'b0;
        over_first_q <= 1'b0;
        blank_q      <= 1'b0;
        blink_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (bus.point && score_q != ALL9) begin
              score_q     <= score_d;
              score_max_q <= (score_d == ALL9);
            end
            if (bus.game_over) begin
              state_q      <= OVER;
              over_first_q <= 1'b1;
            end
          end
          OVER: begin
            over_first_q <= 1'b0;
            // Plain unsigned compare is ordered correctly since nibbles stay 0..9.
            if (over_first_q && score_q > high_q) begin
              high_q     <= score_q;
              new_high_q <= 1'b1;
            end
          end
          default: ;
        endcase

        if (state_q == OVER && new_high_q) begin
          if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blank_q     <= ~blank_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end else begin
          blink_cnt_q <= '0;
          blank_q     <= 1'b0;
        end
      end
    end
  end

  assign bus.digits    = digits_q;
  assign bus.score_max = score_max_q;
  assign bus.new_high  = new_high_q;
  assign bus.blank     = blank_q;

endmodule
